// File: rtl/multi_shift_reg.sv
// Multi-cycle shift/rotate register: loads in parallel, then applies `amount`
// single-bit steps of the captured operation, one per clock, with abort-on-load.
module multi_shift_reg #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_n,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amount,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [2:0] OP_LSR = 3'b000;
    localparam logic [2:0] OP_ASR = 3'b001;
    localparam logic [2:0] OP_LSL = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_SRI = 3'b101;
    localparam logic [2:0] OP_SLI = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    localparam logic [AMT_W-1:0] AMT_ZERO = {AMT_W{1'b0}};
    localparam logic [AMT_W-1:0] AMT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

    // One single-bit step: returns {bit leaving the register, new register value}.
    function automatic logic [WIDTH:0] step_fn(
        input logic [2:0]       step_op,
        input logic [WIDTH-1:0] cur,
        input logic             fill
    );
        logic [WIDTH:0] res;
        case (step_op)
            OP_LSR:  res = {cur[0],       1'b0,         cur[WIDTH-1:1]};
            OP_ASR:  res = {cur[0],       cur[WIDTH-1], cur[WIDTH-1:1]};
            OP_LSL:  res = {cur[WIDTH-1], cur[WIDTH-2:0], 1'b0};
            OP_ROR:  res = {cur[0],       cur[0],       cur[WIDTH-1:1]};
            OP_ROL:  res = {cur[WIDTH-1], cur[WIDTH-2:0], cur[WIDTH-1]};
            OP_SRI:  res = {cur[0],       fill,         cur[WIDTH-1:1]};
            OP_SLI:  res = {cur[WIDTH-1], cur[WIDTH-2:0], fill};
            default: res = {1'b0, cur};
        endcase
        return res;
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               serial_out_q, serial_out_d;
    logic               done_q, done_d;
    logic [2:0]         op_q, op_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     step_s;

    assign step_s = step_fn(op_q, q_q, serial_in);

    // Next-state and datapath decode; load_n wins over start and aborts a run silently.
    always_comb begin
        state_d      = state_q;
        q_d          = q_q;
        serial_out_d = serial_out_q;
        done_d       = 1'b0;
        op_d         = op_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!load_n) begin
                    q_d = load_val;
                end else if (start) begin
                    op_d  = op;
                    cnt_d = amount;
                    if ((amount == AMT_ZERO) || (op == OP_NOP)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!load_n) begin
                    q_d     = load_val;
                    state_d = ST_IDLE;
                end else begin
                    q_d          = step_s[WIDTH-1:0];
                    serial_out_d = step_s[WIDTH];
                    cnt_d        = cnt_q - AMT_ONE;
                    if (cnt_q == AMT_ONE) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            q_q          <= {WIDTH{1'b0}};
            serial_out_q <= 1'b0;
            done_q       <= 1'b0;
            op_q         <= OP_NOP;
            cnt_q        <= AMT_ZERO;
        end else begin
            state_q      <= state_d;
            q_q          <= q_d;
            serial_out_q <= serial_out_d;
            done_q       <= done_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
        end
    end

    assign q          = q_q;
    assign serial_out = serial_out_q;
    assign busy       = (state_q == ST_RUN);
    assign done       = done_q;

endmodule

// File: doc/multi_shift_reg.md
MULTI_SHIFT_REG -- requirements
Module: multi_shift_reg

Interface
REQ-001 Parameter: WIDTH, 8, register width in bits (>= 2).
REQ-002 Parameter: AMT_W, 4, width of the shift-amount field.
REQ-003 Port: clock  in  1  rising-edge clock for all state.
REQ-004 Port: reset_n  in  1  synchronous, active-low reset.
REQ-005 Port: load_n  in  1  active-low parallel load request.
REQ-006 Port: load_val  in  WIDTH  parallel load data.
REQ-007 Port: start  in  1  one-cycle request to begin a multi-cycle shift operation.
REQ-008 Port: op  in  3  operation code; 000 LSR, 001 ASR, 010 LSL, 011 ROR, 100 ROL, 101 SRI, 110 SLI, 111 NOP.
REQ-009 Port: amount  in  AMT_W  number of single-bit shifts to perform (0..2^AMT_W-1).
REQ-010 Port: serial_in  in  1  fill bit for SRI/SLI.
REQ-011 Port: q  out  WIDTH  register contents.
REQ-012 Port: serial_out  out  1  registered copy of the last bit shifted or rotated out.
REQ-013 Port: busy  out  1  high while an operation is in progress.
REQ-014 Port: done  out  1  one-cycle pulse on operation completion.

Function
REQ-015 The FSM SHALL have two states: IDLE (busy=0) and RUN (busy=1).
REQ-016 In IDLE, load_n=0 SHALL load q<=load_val on the next edge; it takes priority over start.
REQ-017 In IDLE, start=1 with load_n=1 SHALL capture op and amount at that edge.
REQ-018 If the captured amount is 0 or op is NOP, done SHALL pulse for the cycle after the capture edge, q SHALL be unchanged, and busy SHALL stay 0.
REQ-019 Otherwise, after capture edge k, busy SHALL be 1 and exactly N=amount single-bit steps SHALL occur at edges k+1..k+N.
REQ-020 At edge k+N, the FSM SHALL return to IDLE and done SHALL be 1 for exactly one cycle.
REQ-021 Each step SHALL update q as follows:
- LSR: fill MSB with 0.
- ASR: fill MSB with the current q[MSB].
- LSL: fill LSB with 0.
- ROR/ROL: rotate by 1.
- SRI: shift right, filling MSB with serial_in.
- SLI: shift left, filling LSB with serial_in.
REQ-022 serial_in SHALL be sampled at each step edge, not at capture.
REQ-023 On each step, serial_out SHALL take the bit leaving the register: q[0] for right operations (LSR, ASR, ROR, SRI), q[WIDTH-1] for left operations (LSL, ROL, SLI).
REQ-024 serial_out SHALL hold its value between steps.
REQ-025 Amounts >= WIDTH SHALL still execute N single steps; the result is not saturated or reduced modulo WIDTH.
REQ-026 During RUN, changes on op, amount and start SHALL be ignored; start is not queued.
REQ-027 During RUN, load_n=0 SHALL abort the operation: q<=load_val, FSM goes to IDLE, busy<=0, and done SHALL NOT pulse.
REQ-028 start asserted in the same cycle that done is high SHALL be accepted (back-to-back operations).

Reset
REQ-029 While reset_n=0 at a rising edge, q, serial_out, busy and done SHALL all become 0 and the FSM SHALL enter IDLE.
REQ-030 Reset SHALL override load_n and start, including mid-operation.
REQ-031 No done pulse SHALL follow a reset.

Verification (WIDTH=8, AMT_W=4)
REQ-032 Load 0x96, start ASR amount=3 -> busy high 3 cycles; q goes 0xCB, 0xE5, 0xF2; done pulses once; serial_out=1.
REQ-033 Load 0x81, start ROL amount=9 -> busy high 9 cycles; final q=0x03; done pulses once.
REQ-034 Load 0x00, start SRI amount=4 with serial_in 1,0,1,1 on successive steps -> q goes 0x80, 0x40, 0xA0, 0xD0.
REQ-035 Load 0x5A, start LSR amount=0 -> done pulses the next cycle; busy stays 0; q stays 0x5A.
REQ-036 Start LSL amount=6 on 0xFF, then load_n=0 with load_val=0x3C after 2 steps -> q=0x3C, busy=0, no done pulse.
REQ-037 Assert reset_n=0 during an ROR run -> q=0x00, busy=0, done=0, serial_out=0; a subsequent start executes normally.
